// File: rtl/reg_wb_pkg.sv
// rtl/reg_wb_pkg.sv - shared types and constants for the register writeback buffer
// Purpose : default geometry, the register-zero constant and the FIFO entry type.
// Ports   : none (package).
// Config  : WB_BYPASS_EN (used by reg_writeback_buffer, not by this package).
package reg_wb_pkg;

  localparam int WB_DEPTH = 4;
  localparam int WB_AW    = 5;
  localparam int WB_DW    = 32;

  localparam logic [WB_AW-1:0] REG_ZERO = '0;

  // One queued register write.
  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_bypass_lookup.sv
// rtl/wb_bypass_lookup.sv - newest-match lookup of pending writes for one read port
// Purpose : combinational priority match of a decode read address against the
//           pending FIFO entries (index 0 = youngest) and the rf output register.
// Ports   : addr            - decode read address
//           ent_addr/data   - FIFO entries ordered youngest first
//           ent_valid       - per-entry occupancy
//           out_valid/addr/data - entry currently presented to the register file
//           hit/data_out    - match flag and newest matching value
// Config  : instantiated only when WB_BYPASS_EN is defined.
module wb_bypass_lookup
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic [AW-1:0]             addr,
  input  logic [DEPTH-1:0][AW-1:0]  ent_addr,
  input  logic [DEPTH-1:0][DW-1:0]  ent_data,
  input  logic [DEPTH-1:0]          ent_valid,
  input  logic                      out_valid,
  input  logic [AW-1:0]             out_addr,
  input  logic [DW-1:0]             out_data,
  output logic                      hit,
  output logic [DW-1:0]             data_out
);

  // Scan from oldest to youngest so later (younger) matches overwrite earlier ones.
  always_comb begin
    hit      = 1'b0;
    data_out = '0;
    if (addr != REG_ZERO) begin
      if (out_valid && out_addr == addr) begin
        hit      = 1'b1;
        data_out = out_data;
      end
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (ent_valid[k] && ent_addr[k] == addr) begin
          hit      = 1'b1;
          data_out = ent_data[k];
        end
      end
    end
  end

endmodule

// File: rtl/reg_writeback_buffer.sv
// rtl/reg_writeback_buffer.sv - in-order writeback FIFO between ALU/load producers and the register file
// Purpose : accepts up to two results per cycle (ALU older than load), drops
//           writes to register 0, drains one write per cycle to rf_*, and
//           optionally forwards pending values to the decode read ports.
// Ports   : clk, reset (sync, active-high)
//           alu_valid/alu_reg/alu_data/alu_ready - ALU result handshake
//           ld_valid/ld_reg/ld_data/ld_ready     - load result handshake
//           rf_we/rf_waddr/rf_wdata              - register file write port
//           count                                - occupied FIFO entries
//           rs_addr/rt_addr -> rs_hit/rs_data, rt_hit/rt_data - pending-write lookup
// Config  : WB_BYPASS_EN - builds the lookup; otherwise hit/data outputs are 0.
module reg_writeback_buffer
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic [AW-1:0]              alu_reg,
  input  logic [DW-1:0]              alu_data,
  output logic                       alu_ready,
  input  logic                       ld_valid,
  input  logic [AW-1:0]              ld_reg,
  input  logic [DW-1:0]              ld_data,
  output logic                       ld_ready,
  output logic                       rf_we,
  output logic [AW-1:0]              rf_waddr,
  output logic [DW-1:0]              rf_wdata,
  output logic [$clog2(DEPTH):0]     count,
  input  logic [AW-1:0]              rs_addr,
  input  logic [AW-1:0]              rt_addr,
  output logic                       rs_hit,
  output logic                       rt_hit,
  output logic [DW-1:0]              rs_data,
  output logic [DW-1:0]              rt_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t      mem [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [CW-1:0]  free;
  logic           alu_take;
  logic           ld_take;
  logic [1:0]     n_push;
  logic           pop;

  // Credit is based on the registered count only; a pop in this cycle frees
  // nothing until the next edge, so accepted pushes always fit.
  assign free      = CW'(DEPTH) - count;
  assign alu_ready = (free >= CW'(1));
  assign ld_ready  = (alu_valid && alu_ready) ? (free >= CW'(2)) : (free >= CW'(1));

  // Register-0 transfers complete the handshake but are not stored.
  assign alu_take = alu_valid && alu_ready && (alu_reg != REG_ZERO);
  assign ld_take  = ld_valid  && ld_ready  && (ld_reg  != REG_ZERO);
  assign n_push   = {1'b0, alu_take} + {1'b0, ld_take};
  assign pop      = (count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (pop) begin
        rf_we    <= 1'b1;
        rf_waddr <= mem[head].addr;
        rf_wdata <= mem[head].data;
        head     <= head + 1'b1;
      end else begin
        rf_we    <= 1'b0;
      end
      tail  <= tail + PW'(n_push);
      count <= count + CW'(n_push) - CW'(pop);
    end
  end

  // Entry storage needs no reset: occupancy is tracked by head/tail/count.
  // The ALU entry lands at tail, the load entry right behind it when both push.
  always_ff @(posedge clk) begin
    if (alu_take) begin
      mem[tail] <= '{addr: alu_reg, data: alu_data};
    end
    if (ld_take) begin
      mem[alu_take ? tail + 1'b1 : tail] <= '{addr: ld_reg, data: ld_data};
    end
  end

`ifdef WB_BYPASS_EN
  logic [DEPTH-1:0][AW-1:0] ord_addr;
  logic [DEPTH-1:0][DW-1:0] ord_data;
  logic [DEPTH-1:0]         ord_valid;

  // Present the queue youngest-first: slot k holds entry tail-1-k.
  always_comb begin
    ord_addr  = '0;
    ord_data  = '0;
    ord_valid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ord_addr[k]  = mem[tail - PW'(k + 1)].addr;
      ord_data[k]  = mem[tail - PW'(k + 1)].data;
      ord_valid[k] = (CW'(k) < count);
    end
  end

  wb_bypass_lookup #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_rs_lookup (
    .addr      (rs_addr),
    .ent_addr  (ord_addr),
    .ent_data  (ord_data),
    .ent_valid (ord_valid),
    .out_valid (rf_we),
    .out_addr  (rf_waddr),
    .out_data  (rf_wdata),
    .hit       (rs_hit),
    .data_out  (rs_data)
  );

  wb_bypass_lookup #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_rt_lookup (
    .addr      (rt_addr),
    .ent_addr  (ord_addr),
    .ent_data  (ord_data),
    .ent_valid (ord_valid),
    .out_valid (rf_we),
    .out_addr  (rf_waddr),
    .out_data  (rf_wdata),
    .hit       (rt_hit),
    .data_out  (rt_data)
  );
`else
  // Read addresses are intentionally ignored when forwarding is not built.
  logic unused_addr;
  assign unused_addr = ^{rs_addr, rt_addr};
  assign rs_hit  = 1'b0;
  assign rt_hit  = 1'b0;
  assign rs_data = '0;
  assign rt_data = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_buffer.sv
// tb/tb_reg_writeback_buffer.sv - self-checking bench for reg_writeback_buffer
module tb_reg_writeback_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk;
  logic          reset;
  logic          alu_valid;
  logic [AW-1:0] alu_reg;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_reg;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [2:0]    count;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic          rs_hit;
  logic          rt_hit;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;

  reg_writeback_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_reg   (alu_reg),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .ld_valid  (ld_valid),
    .ld_reg    (ld_reg),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .count     (count),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rs_hit    (rs_hit),
    .rt_hit    (rt_hit),
    .rs_data   (rs_data),
    .rt_data   (rt_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pending writes as a plain queue (front = oldest) plus the
  // value the register-file port is presenting this cycle.
  logic [AW-1:0] qa[$];
  logic [DW-1:0] qd[$];
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic          acc_alu;
  logic          acc_ld;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void lookup(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
`ifdef WB_BYPASS_EN
    if (a != 0) begin
      for (int i = qa.size() - 1; i >= 0; i--) begin
        if (!h && qa[i] == a) begin
          h = 1'b1;
          d = qd[i];
        end
      end
      if (!h && m_we && m_waddr == a) begin
        h = 1'b1;
        d = m_wdata;
      end
    end
`endif
  endfunction

  // One clock: drive at the falling edge, check everything, then advance the model
  // to what the next rising edge must produce.
  task automatic cycle(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                       input logic lv, input logic [AW-1:0] lr, input logic [DW-1:0] ldd,
                       input logic [AW-1:0] rsa, input logic [AW-1:0] rta);
    int n;
    int fr;
    logic ear, elr, eh;
    logic [DW-1:0] ed;
    @(negedge clk);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    ld_valid  = lv; ld_reg  = lr; ld_data  = ldd;
    rs_addr   = rsa; rt_addr = rta;
    #1;
    n   = qa.size();
    fr  = DEPTH - n;
    ear = (fr >= 1);
    elr = (av && ear) ? (fr >= 2) : (fr >= 1);
    chk("count", 64'(count), 64'(n));
    chk("alu_ready", 64'(alu_ready), 64'(ear));
    chk("ld_ready", 64'(ld_ready), 64'(elr));
    chk("rf_we", 64'(rf_we), 64'(m_we));
    chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
    chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
    lookup(rsa, eh, ed);
    chk("rs_hit", 64'(rs_hit), 64'(eh));
    chk("rs_data", 64'(rs_data), 64'(ed));
    lookup(rta, eh, ed);
    chk("rt_hit", 64'(rt_hit), 64'(eh));
    chk("rt_data", 64'(rt_data), 64'(ed));
    if (n > 0) begin
      m_we    = 1'b1;
      m_waddr = qa.pop_front();
      m_wdata = qd.pop_front();
    end else begin
      m_we = 1'b0;
    end
    acc_alu = av && ear;
    acc_ld  = lv && elr;
    if (acc_alu && ar != 0) begin qa.push_back(ar); qd.push_back(ad); end
    if (acc_ld  && lr != 0) begin qa.push_back(lr); qd.push_back(ldd); end
  endtask

  task automatic idle(input logic [AW-1:0] rsa);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, rsa, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    alu_valid = 1'b0; ld_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    qa.delete();
    qd.delete();
    m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_rs_hit", 64'(rs_hit), 64'd0);
    chk("rst_rt_hit", 64'(rt_hit), 64'd0);
  endtask

  logic          r_av, r_lv;
  logic [AW-1:0] r_ar, r_lr;
  logic [DW-1:0] r_ad, r_ld;

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_reg  = '0; ld_data  = '0;
    rs_addr = '0; rt_addr = '0;
    m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    acc_alu = 1'b0; acc_ld = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // Single ALU write r3 = 0xAA.
    cycle(1'b1, 5'd3, 32'hAA, 1'b0, '0, '0, '0, '0);
    chk("single_alu_ready", 64'(alu_ready), 64'd1);
    idle('0);
    chk("single_count_1", 64'(count), 64'd1);
    chk("single_no_we_yet", 64'(rf_we), 64'd0);
    idle('0);
    chk("single_we", 64'(rf_we), 64'd1);
    chk("single_waddr", 64'(rf_waddr), 64'd3);
    chk("single_wdata", 64'(rf_wdata), 64'hAA);
    chk("single_count_0", 64'(count), 64'd0);
    idle('0);

    // Same-cycle ALU r5 and load r6: ALU drains first.
    cycle(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, '0, '0);
    idle('0);
    chk("pair_count_2", 64'(count), 64'd2);
    idle('0);
    chk("pair_first_addr", 64'(rf_waddr), 64'd5);
    chk("pair_first_data", 64'(rf_wdata), 64'h11);
    idle('0);
    chk("pair_second_we", 64'(rf_we), 64'd1);
    chk("pair_second_addr", 64'(rf_waddr), 64'd6);
    chk("pair_second_data", 64'(rf_wdata), 64'h22);
    idle('0);
    chk("pair_done_we", 64'(rf_we), 64'd0);

    // Bursts of two per cycle: at count 3 with alu_valid, load is refused.
    cycle(1'b1, 5'd8,  32'h8,  1'b1, 5'd9,  32'h9,  '0, '0);
    cycle(1'b1, 5'd10, 32'hA,  1'b1, 5'd11, 32'hB,  '0, '0);
    cycle(1'b1, 5'd12, 32'hC,  1'b1, 5'd13, 32'hD,  '0, '0);
    chk("burst_count_3", 64'(count), 64'd3);
    chk("burst_alu_ready", 64'(alu_ready), 64'd1);
    chk("burst_ld_refused", 64'(ld_ready), 64'd0);
    cycle(1'b0, '0, '0, 1'b1, 5'd13, 32'hD, '0, '0);
    repeat (6) idle('0);

    // Register 0 write: handshake completes, nothing stored.
    cycle(1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0, 5'd0, 5'd0);
    chk("r0_alu_ready", 64'(alu_ready), 64'd1);
    idle(5'd0);
    chk("r0_count", 64'(count), 64'd0);
    idle(5'd0);
    chk("r0_no_we", 64'(rf_we), 64'd0);
    chk("r0_no_hit", 64'(rs_hit), 64'd0);

    // Write-after-write to r7: newest value forwarded, then nothing pending.
    cycle(1'b1, 5'd7, 32'h1, 1'b0, '0, '0, 5'd7, '0);
    cycle(1'b1, 5'd7, 32'h2, 1'b0, '0, '0, 5'd7, '0);
    idle(5'd7);
`ifdef WB_BYPASS_EN
    chk("waw_hit", 64'(rs_hit), 64'd1);
    chk("waw_data", 64'(rs_data), 64'h2);
`else
    chk("waw_hit_off", 64'(rs_hit), 64'd0);
    chk("waw_data_off", 64'(rs_data), 64'd0);
`endif
    idle(5'd7);
    chk("waw_last_addr", 64'(rf_waddr), 64'd7);
    chk("waw_last_data", 64'(rf_wdata), 64'h2);
    idle(5'd7);
    chk("waw_drained_hit", 64'(rs_hit), 64'd0);

    // Reset with three entries queued.
    cycle(1'b1, 5'd14, 32'hE, 1'b1, 5'd15, 32'hF, '0, '0);
    cycle(1'b1, 5'd16, 32'h10, 1'b1, 5'd17, 32'h11, '0, '0);
    idle('0);
    chk("pre_reset_count", 64'(count), 64'd3);
    do_reset();
    repeat (4) begin
      idle('0);
      chk("post_reset_no_we", 64'(rf_we), 64'd0);
    end

    // Randomized traffic; producers hold a refused transfer.
    r_av = 1'b0; r_lv = 1'b0; r_ar = '0; r_lr = '0; r_ad = '0; r_ld = '0;
    for (int i = 0; i < 400; i++) begin
      if (!r_av || acc_alu) begin
        r_av = ($urandom_range(0, 99) < 60);
        r_ar = AW'($urandom_range(0, 7));
        r_ad = $urandom;
      end
      if (!r_lv || acc_ld) begin
        r_lv = ($urandom_range(0, 99) < 50);
        r_lr = AW'($urandom_range(0, 7));
        r_ld = $urandom;
      end
      cycle(r_av, r_ar, r_ad, r_lv, r_lr, r_ld,
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      if (!r_av) acc_alu = 1'b0;
      if (!r_lv) acc_ld = 1'b0;
      if (i == 200) do_reset();
    end
    repeat (6) idle('0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
